// File: rtl/multi_start_sync_if.sv
// Trigger, configuration and status bundle for multi_start_sync.
// Optional stats outputs are present only when MULTI_START_SYNC_STATS_EN is defined.
interface multi_start_sync_if #(
  parameter int unsigned N_CH   = 3,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned STAT_W = 16
);
  logic [N_CH-1:0]   impulse;
  logic [N_CH-1:0]   ch_mask;
  logic [CNT_W-1:0]  hold_len;
  logic [CNT_W-1:0]  timeout_len;
  logic              auto_rearm;
  logic              rearm;
  logic              clr;
  logic              counted;
  logic              start_pulse;
  logic              timeout_err;
  logic              busy;
  logic [N_CH-1:0]   ch_seen;
`ifdef MULTI_START_SYNC_STATS_EN
  logic [STAT_W-1:0] seq_count;
  logic [STAT_W-1:0] to_count;
`endif

  modport master (
    output impulse, ch_mask, hold_len, timeout_len, auto_rearm, rearm, clr,
`ifdef MULTI_START_SYNC_STATS_EN
    input  seq_count, to_count,
`endif
    input  counted, start_pulse, timeout_err, busy, ch_seen
  );

  modport slave (
    input  impulse, ch_mask, hold_len, timeout_len, auto_rearm, rearm, clr,
`ifdef MULTI_START_SYNC_STATS_EN
    output seq_count, to_count,
`endif
    output counted, start_pulse, timeout_err, busy, ch_seen
  );
endinterface

// File: rtl/multi_start_sync.sv
// Waits for every enabled impulse channel to fire (any order), then opens a hold window.
// Define MULTI_START_SYNC_STATS_EN to add saturating start/timeout statistics counters.
module multi_start_sync #(
  parameter int unsigned N_CH   = 3,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  multi_start_sync_if.slave bus
);

  typedef enum logic [1:0] {COLLECT, HOLD, DONE} state_e;

  state_e           state_q, state_d;
  logic [N_CH-1:0]  seen_q, seen_d, seen_nxt;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] hold_len_q, hold_len_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d, to_inc;
  logic             start_q, start_d;
  logic             terr_q, terr_d;
  logic             complete, running, timed_out;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= COLLECT;
      seen_q     <= '0;
      hold_cnt_q <= '0;
      hold_len_q <= '0;
      to_cnt_q   <= '0;
      start_q    <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      seen_q     <= seen_d;
      hold_cnt_q <= hold_cnt_d;
      hold_len_q <= hold_len_d;
      to_cnt_q   <= to_cnt_d;
      start_q    <= start_d;
      terr_q     <= terr_d;
    end
  end

  always_comb begin
    seen_nxt   = seen_q | (bus.impulse & bus.ch_mask);
    complete   = (bus.ch_mask != '0) && ((seen_nxt & bus.ch_mask) == bus.ch_mask);
    running    = (seen_q & bus.ch_mask) != '0;
    to_inc     = to_cnt_q + CNT_W'(1);
    timed_out  = running && (bus.timeout_len != '0) && (to_inc == bus.timeout_len);

    state_d    = state_q;
    seen_d     = seen_q;
    hold_cnt_d = hold_cnt_q;
    hold_len_d = hold_len_q;
    to_cnt_d   = to_cnt_q;
    start_d    = 1'b0;
    terr_d     = 1'b0;

    if (bus.clr) begin
      state_d    = COLLECT;
      seen_d     = '0;
      hold_cnt_d = '0;
      hold_len_d = '0;
      to_cnt_d   = '0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          seen_d = seen_nxt;
          // completion is tested first so a coinciding timeout is suppressed
          if (complete) begin
            state_d    = HOLD;
            start_d    = 1'b1;
            hold_cnt_d = CNT_W'(1);
            hold_len_d = (bus.hold_len == '0) ? CNT_W'(1) : bus.hold_len;
            to_cnt_d   = '0;
          end else if (timed_out) begin
            terr_d   = 1'b1;
            seen_d   = '0;
            to_cnt_d = '0;
          end else if (running && (bus.timeout_len != '0)) begin
            to_cnt_d = to_inc;
          end else begin
            to_cnt_d = '0;
          end
        end
        HOLD: begin
          if (hold_cnt_q >= hold_len_q) begin
            state_d    = bus.auto_rearm ? COLLECT : DONE;
            seen_d     = '0;
            hold_cnt_d = '0;
            to_cnt_d   = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.rearm) state_d = COLLECT;
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  assign bus.counted     = (state_q == HOLD);
  assign bus.start_pulse = start_q;
  assign bus.timeout_err = terr_q;
  assign bus.busy        = (state_q == HOLD) || ((state_q == COLLECT) && running);
  assign bus.ch_seen     = seen_q;

`ifdef MULTI_START_SYNC_STATS_EN
  logic [STAT_W-1:0] seq_q, seq_d, tocnt_q, tocnt_d;

  always_comb begin
    seq_d   = seq_q;
    tocnt_d = tocnt_q;
    if (bus.clr) begin
      seq_d   = '0;
      tocnt_d = '0;
    end else begin
      if (start_d && (seq_q != '1))   seq_d   = seq_q + STAT_W'(1);
      if (terr_d  && (tocnt_q != '1)) tocnt_d = tocnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seq_q   <= '0;
      tocnt_q <= '0;
    end else begin
      seq_q   <= seq_d;
      tocnt_q <= tocnt_d;
    end
  end

  assign bus.seq_count = seq_q;
  assign bus.to_count  = tocnt_q;
`endif

endmodule
